// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM state encoding.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and keep the difference only when it did not borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   a_next,
  output logic             q_bit
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] t;
  logic           unused_a_msb;

  // The partial remainder is always below the divisor, so its top bit never carries data.
  assign unused_a_msb = a[WIDTH];

  always_comb begin
    s      = {a[WIDTH-1:0], q_msb};
    t      = s - {1'b0, d};
    a_next = t[WIDTH] ? s : t;
    q_bit  = ~t[WIDTH];
  end

endmodule

// File: rtl/restoring_divider_n.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides;
// one quotient bit per cycle, zero divisor short-circuits straight to the result.
module restoring_divider_n #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  import div_pkg::*;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_n;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   a_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .a_next (a_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_n   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == LAST_ITER) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_n;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            q_q   <= dividend;
            d_q   <= divisor;
            a_q   <= '0;
            cnt_q <= '0;
            // A zero divisor never iterates; the result is fixed at accept time.
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          a_q   <= a_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            quotient    <= q_next;
            remainder   <= a_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_n.sv
// Bench for restoring_divider_n at WIDTH=4 and WIDTH=8: directed table, corner sequences,
// and random operands against an arithmetic reference model.
module tb_restoring_divider_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid4, out_ready4, in_valid8, out_ready8;
  logic [3:0] dividend4, divisor4;
  logic [7:0] dividend8, divisor8;
  logic       in_ready4, out_valid4, dbz4, busy4;
  logic       in_ready8, out_valid8, dbz8, busy8;
  logic [3:0] quotient4, remainder4;
  logic [7:0] quotient8, remainder8;

  restoring_divider_n #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .dividend(dividend4), .divisor(divisor4), .out_valid(out_valid4),
    .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4),
    .div_by_zero(dbz4), .busy(busy4)
  );

  restoring_divider_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8),
    .out_ready(out_ready8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dbz8), .busy(busy8)
  );

  int   passed = 0;
  int   total  = 0;
  logic sel8   = 1'b0;

  logic [7:0] mux_q, mux_r;
  logic       mux_ov, mux_ir, mux_dz, mux_busy;
  always_comb begin
    mux_q    = sel8 ? quotient8  : {4'b0, quotient4};
    mux_r    = sel8 ? remainder8 : {4'b0, remainder4};
    mux_ov   = sel8 ? out_valid8 : out_valid4;
    mux_ir   = sel8 ? in_ready8  : in_ready4;
    mux_dz   = sel8 ? dbz8       : dbz4;
    mux_busy = sel8 ? busy8      : busy4;
  end

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic drive_in(input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sel8) begin
      in_valid8 = v; dividend8 = a; divisor8 = b;
    end else begin
      in_valid4 = v; dividend4 = a[3:0]; divisor4 = b[3:0];
    end
  endtask

  task automatic set_ready(input logic r);
    if (sel8) out_ready8 = r;
    else      out_ready4 = r;
  endtask

  // Reference: plain integer division with the zero-divisor convention.
  task automatic model(input int w, input logic [7:0] a, input logic [7:0] b, output vec_t v);
    v.a = a; v.b = b;
    if (b == 8'd0) begin
      v.q = (w == 8) ? 8'hFF : 8'h0F; v.r = a; v.dz = 1'b1; v.lat = 0;
    end else begin
      v.q = a / b; v.r = a % b; v.dz = 1'b0; v.lat = w;
    end
  endtask

  task automatic run(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    check({name, " in_ready"}, int'(mux_ir), 1);
    drive_in(1'b1, v.a, v.b);
    @(posedge clk); #1;
    drive_in(1'b0, 8'($urandom), 8'($urandom));
    check({name, " busy"}, int'(mux_busy), int'(!v.dz));
    lat = 0;
    while (!mux_ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, v.lat);
    check({name, " quotient"}, int'(mux_q), int'(v.q));
    check({name, " remainder"}, int'(mux_r), int'(v.r));
    check({name, " div_by_zero"}, int'(mux_dz), int'(v.dz));
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check({name, " out_valid drop"}, int'(mux_ov), 0);
    check({name, " back to idle"}, int'(mux_ir), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  vec_t tbl[8];
  vec_t v;
  int   ov_seen;

  initial begin
    tbl[0] = '{8'd13, 8'd4,  8'd3,  8'd1,  1'b0, 4};
    tbl[1] = '{8'd7,  8'd0,  8'd15, 8'd7,  1'b1, 0};
    tbl[2] = '{8'd3,  8'd9,  8'd0,  8'd3,  1'b0, 4};
    tbl[3] = '{8'd15, 8'd1,  8'd15, 8'd0,  1'b0, 4};
    tbl[4] = '{8'd0,  8'd5,  8'd0,  8'd0,  1'b0, 4};
    tbl[5] = '{8'd15, 8'd15, 8'd1,  8'd0,  1'b0, 4};
    tbl[6] = '{8'd0,  8'd0,  8'd15, 8'd0,  1'b1, 0};
    tbl[7] = '{8'd9,  8'd2,  8'd4,  8'd1,  1'b0, 4};

    // Reset with both handshakes asserted: reset must win.
    reset = 1'b1;
    in_valid4 = 1'b1; dividend4 = 4'd9; divisor4 = 4'd3; out_ready4 = 1'b1;
    in_valid8 = 1'b1; dividend8 = 8'd9; divisor8 = 8'd3; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", int'(in_ready4), 1);
    check("reset out_valid", int'(out_valid4), 0);
    check("reset busy", int'(busy4), 0);
    check("reset quotient", int'(quotient4), 0);
    check("reset remainder", int'(remainder4), 0);
    check("reset div_by_zero", int'(dbz4), 0);
    check("reset w8 out_valid", int'(out_valid8), 0);
    reset = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;

    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Consumer stalls for 5 cycles while new operands are offered.
    @(negedge clk);
    drive_in(1'b1, 8'd13, 8'd4);
    @(posedge clk); #1;
    drive_in(1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 40 && !mux_ov; i++) begin
      @(posedge clk); #1;
    end
    drive_in(1'b1, 8'd5, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall out_valid", int'(mux_ov), 1);
      check("stall in_ready", int'(mux_ir), 0);
      check("stall quotient", int'(mux_q), 3);
      check("stall remainder", int'(mux_r), 1);
    end
    drive_in(1'b0, 8'd0, 8'd0);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check("stall release out_valid", int'(mux_ov), 0);
    check("stall release in_ready", int'(mux_ir), 1);
    @(posedge clk); #1;
    check("stall no accept busy", int'(mux_busy), 0);

    // Reset mid-calculation aborts with no result.
    @(negedge clk);
    drive_in(1'b1, 8'd13, 8'd4);
    @(posedge clk); #1;
    drive_in(1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort in_ready", int'(mux_ir), 1);
    check("abort busy", int'(mux_busy), 0);
    check("abort out_valid", int'(mux_ov), 0);
    check("abort quotient", int'(mux_q), 0);
    check("abort remainder", int'(mux_r), 0);
    ov_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mux_ov) ov_seen++;
    end
    check("abort no out_valid", ov_seen, 0);
    run(tbl[7], "after abort 9/2");

    // Reset while holding a zero-divisor result drops it.
    @(negedge clk);
    drive_in(1'b1, 8'd7, 8'd0);
    @(posedge clk); #1;
    drive_in(1'b0, 8'd0, 8'd0);
    check("done before reset", int'(mux_ov), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("done reset out_valid", int'(mux_ov), 0);
    check("done reset div_by_zero", int'(mux_dz), 0);

    for (int i = 0; i < 30; i++) begin
      model(4, {4'b0, 4'($urandom)}, {4'b0, 4'($urandom)}, v);
      run(v, $sformatf("rand4_%0d", i));
    end

    sel8 = 1'b1;
    model(8, 8'd255, 8'd16, v);
    run(v, "w8 255/16");
    model(8, 8'd200, 8'd0, v);
    run(v, "w8 200/0");
    model(8, 8'd255, 8'd1, v);
    run(v, "w8 255/1");
    for (int i = 0; i < 20; i++) begin
      model(8, 8'($urandom), 8'($urandom_range(0, 20)), v);
      run(v, $sformatf("rand8_%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
